// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive buffer: entry layout and default depth.
package uart_pkg;

    localparam int DEPTH_DEF = 8;
    localparam int DATA_W    = 8;
    localparam int ENTRY_W   = 10;

    // Field positions inside a stored entry: {stop, parity, data}
    localparam int DATA_LSB  = 0;
    localparam int DATA_MSB  = 7;
    localparam int PAR_BIT   = 8;
    localparam int STP_BIT   = 9;

    typedef struct packed {
        logic              stp_err;
        logic              par_err;
        logic [DATA_W-1:0] data;
    } rx_entry_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word-fall-through FIFO holding received UART entries.
// Pointers carry one extra MSB so full and empty are never ambiguous.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  rx_entry_t     wr_data,
    input  logic          rd_en,
    output rx_entry_t     rd_data,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count
);

    rx_entry_t   mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_rd;
    logic        do_wr;

    assign count   = wr_ptr - rd_ptr;
    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // A pop frees the head slot in the same cycle, so a full FIFO still
    // accepts a write when it is popped; rd_en on empty is ignored.
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    // Pointer update; reset returns both pointers to zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents are left untouched by reset.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/uart_rx_buffer.sv
// UART receive buffer: captures one frame per data_valid rising edge into a
// FWFT FIFO, tags it with parity/stop errors and flags lost frames.
// Build option: define UART_RX_ERR_DROP_EN to discard frames carrying errors.
module uart_rx_buffer
    import uart_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      data_valid,
    input  logic [DATA_W-1:0]         P_DATA,
    input  logic                      Parity_Error,
    input  logic                      Stop_Error,
    input  logic                      rd_en,
    input  logic                      clr_ovr,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      rd_par_err,
    output logic                      rd_stp_err,
    output logic                      empty,
    output logic                      full,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      overrun
);

    logic      dv_q;
    logic      capture;
    logic      drop;
    logic      wr_req;
    logic      lost;
    rx_entry_t wr_entry;
    rx_entry_t head;

    assign capture = data_valid && !dv_q;

`ifdef UART_RX_ERR_DROP_EN
    assign drop = Parity_Error || Stop_Error;
`else
    assign drop = 1'b0;
`endif

    assign wr_req   = capture && !drop;
    // A frame is lost only when full and no pop frees a slot this cycle.
    assign lost     = wr_req && full && !(rd_en && !empty);
    assign wr_entry = '{stp_err: Stop_Error, par_err: Parity_Error, data: P_DATA};

    // Previous data_valid for rising-edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) dv_q <= 1'b0;
        else      dv_q <= data_valid;
    end

    // Sticky overrun; a new loss wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         overrun <= 1'b0;
        else if (lost)    overrun <= 1'b1;
        else if (clr_ovr) overrun <= 1'b0;
    end

    uart_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_req),
        .wr_data (wr_entry),
        .rd_en   (rd_en),
        .rd_data (head),
        .empty   (empty),
        .full    (full),
        .count   (count)
    );

    assign rd_data    = head.data;
    assign rd_par_err = head.par_err;
    assign rd_stp_err = head.stp_err;

endmodule
